// File: rtl/uart_cmd_ctrl.sv
// Framed-command parser for the UART receive path: SYNC/ADDR/LEN/DATA/CHK frames
// are checked, buffered, and committed as a burst of register writes.
module uart_cmd_ctrl #(
    parameter int         FPGA_clk_freq = 50000000,
    parameter int         TIMEOUT_US    = 1000,
    parameter int         MAX_LEN       = 8,
    parameter logic [7:0] SYNC_BYTE     = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    output logic       o_WR_EN,
    output logic [7:0] o_WR_ADDR,
    output logic [7:0] o_WR_DATA,
    output logic       o_FRAME_OK,
    output logic       o_FRAME_ERR,
    output logic [7:0] o_ERR_CNT,
    output logic       o_BUSY
);

    localparam int              TIMEOUT_CLKS = (FPGA_clk_freq / 1000000) * TIMEOUT_US;
    localparam int              TO_W         = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TO_W-1:0] TO_LAST      = TO_W'(TIMEOUT_CLKS - 1);
    localparam int              IDX_W        = $clog2(MAX_LEN + 1);
    localparam int              BUF_AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]      MAX_LEN_B    = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CHK,
        S_COMMIT
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       xor_q, xor_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TO_W-1:0]  tcnt_q, tcnt_d;
    logic             wr_en_q, wr_en_d;
    logic [7:0]       wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             ok_q, ok_d;
    logic             err_q, err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic             busy_q, busy_d;

    logic             buf_we;
    logic             frame_err;
    logic [7:0]       idx_b;
    logic [7:0]       data_buf_q [2**BUF_AW];

    assign idx_b = 8'(idx_q);

    // NOTE: every variable assigned below gets a default first, so no path
    // through the case statements can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        xor_d     = xor_q;
        idx_d     = idx_q;
        tcnt_d    = '0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        ok_d      = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        buf_we    = 1'b0;
        frame_err = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) begin
                    state_d = S_ADDR;
                end
            end

            S_ADDR, S_LEN, S_DATA, S_CHK: begin
                tcnt_d = tcnt_q + TO_W'(1);
                // An arriving byte wins over a timeout expiring on the same edge.
                if (i_RX_DV) begin
                    tcnt_d = '0;
                    unique case (state_q)
                        S_ADDR: begin
                            addr_d  = i_RX_Byte;
                            xor_d   = i_RX_Byte;
                            state_d = S_LEN;
                        end
                        S_LEN: begin
                            if ((i_RX_Byte == 8'd0) || (i_RX_Byte > MAX_LEN_B)) begin
                                frame_err = 1'b1;
                            end else begin
                                len_d   = i_RX_Byte;
                                xor_d   = xor_q ^ i_RX_Byte;
                                idx_d   = '0;
                                state_d = S_DATA;
                            end
                        end
                        S_DATA: begin
                            buf_we = 1'b1;
                            xor_d  = xor_q ^ i_RX_Byte;
                            idx_d  = idx_q + IDX_W'(1);
                            if (idx_b == (len_q - 8'd1)) begin
                                state_d = S_CHK;
                            end
                        end
                        S_CHK: begin
                            if (i_RX_Byte == xor_q) begin
                                // The first write issues on the CHK edge itself.
                                wr_en_d   = 1'b1;
                                wr_addr_d = addr_q;
                                wr_data_d = data_buf_q[0];
                                idx_d     = IDX_W'(1);
                                state_d   = S_COMMIT;
                            end else begin
                                frame_err = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end else if (tcnt_q == TO_LAST) begin
                    frame_err = 1'b1;
                end
            end

            S_COMMIT: begin
                if (idx_b == len_q) begin
                    ok_d    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q + idx_b;
                    wr_data_d = data_buf_q[idx_q[BUF_AW-1:0]];
                    idx_d     = idx_q + IDX_W'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase

        if (frame_err) begin
            state_d = S_IDLE;
            tcnt_d  = '0;
            err_d   = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            xor_q     <= '0;
            idx_q     <= '0;
            tcnt_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            xor_q     <= xor_d;
            idx_q     <= idx_d;
            tcnt_q    <= tcnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ok_q      <= ok_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            busy_q    <= busy_d;
        end
    end

    // NOTE: the payload buffer has no reset; it is always written before it is
    // read within a frame, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            data_buf_q[idx_q[BUF_AW-1:0]] <= i_RX_Byte;
        end
    end

    assign o_WR_EN     = wr_en_q;
    assign o_WR_ADDR   = wr_addr_q;
    assign o_WR_DATA   = wr_data_q;
    assign o_FRAME_OK  = ok_q;
    assign o_FRAME_ERR = err_q;
    assign o_ERR_CNT   = err_cnt_q;
    assign o_BUSY      = busy_q;

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Framed-command controller for the UART receive path. It consumes the byte/valid stream from the UART receiver, parses sync/address/length/payload/checksum frames, and buffers the payload. Only frames that pass every check are committed, as a burst of register writes to the watch configuration/time register file. It also reports per-frame success or error pulses and keeps a saturating error count.

## Interface
- `FPGA_clk_freq`, 50000000: clock frequency in Hz.
- `TIMEOUT_US`, 1000: inter-byte timeout in µs. `TIMEOUT_CLKS = (FPGA_clk_freq/1000000)*TIMEOUT_US`.
- `MAX_LEN`, 8: maximum payload bytes per frame. Legal range 1..255.
- `SYNC_BYTE`, 8'hA5: frame start marker.

Ports:
- `clk`  in  1  single clock for the block.
- `rst_n`  in  1  reset; synchronous and active-low.
- `i_RX_DV`  in  1  one-cycle pulse: `i_RX_Byte` is valid.
- `i_RX_Byte`  in  8  received byte.
- `o_WR_EN`  out  1  register-write strobe, one cycle per byte.
- `o_WR_ADDR`  out  8  write address.
- `o_WR_DATA`  out  8  write data.
- `o_FRAME_OK`  out  1  one-cycle pulse after a frame's writes complete.
- `o_FRAME_ERR`  out  1  one-cycle pulse when a frame is rejected.
- `o_ERR_CNT`  out  8  count of rejected frames; saturates at 255.
- `o_BUSY`  out  1  high in every state except IDLE.

## Operation
- Frame format: `SYNC`, `ADDR`, `LEN`, `D[0..LEN-1]`, `CHK`.
  - `CHK` = XOR of `ADDR`, `LEN` and all `D` bytes. `SYNC` is excluded.
- States: IDLE, ADDR, LEN, DATA, CHK, COMMIT.
- IDLE:
  - A byte equal to `SYNC_BYTE` moves to ADDR.
  - Any other byte is discarded silently; no error is raised.
- ADDR: latch the address, seed the running XOR with it, then go to LEN.
- LEN:
  - 0 or greater than `MAX_LEN`: error, return to IDLE.
  - Otherwise latch the length, fold it into the XOR, clear the index, and go to DATA.
- DATA:
  - Store each byte in `buf[idx]`, fold it into the XOR, and increment `idx`.
  - After byte `LEN-1`, go to CHK.
  - A byte equal to `SYNC_BYTE` is ordinary data here; it does not resync the parser.
- CHK:
  - Received byte equals the running XOR: go to COMMIT.
  - Otherwise: error, return to IDLE, and write nothing.
- COMMIT:
  - Issue one write per cycle for i = 0..LEN-1: `o_WR_ADDR = ADDR+i` (8-bit wrap, mod 256) and `o_WR_DATA = buf[i]`.
  - Then pulse `o_FRAME_OK` and return to IDLE.
  - `i_RX_DV` is ignored during COMMIT. At any legal baud rate, byte spacing is far longer than `MAX_LEN` cycles, so no byte is lost.
- Timeout:
  - In states ADDR through CHK, a counter counts cycles since the last accepted byte.
  - It is cleared on every `i_RX_DV` and held at 0 in IDLE and COMMIT.
  - Reaching `TIMEOUT_CLKS` raises an error and returns the FSM to IDLE.
- Error action:
  - Pulse `o_FRAME_ERR`.
  - Increment `o_ERR_CNT` unless it is already 255.
  - Return to IDLE; the partial buffer is discarded and no writes are issued.
- Reset (`rst_n` = 0 at a clock edge):
  - State returns to IDLE.
  - `o_WR_EN`, `o_WR_ADDR`, `o_WR_DATA`, `o_FRAME_OK`, `o_FRAME_ERR`, `o_BUSY` and `o_ERR_CNT` all go to 0. The timeout counter, `idx` and the XOR are cleared.
  - Buffer contents need not be cleared.
  - Reset in the middle of a frame or a COMMIT aborts it at once: no further writes, no OK or ERR pulse, and no count change.

## Timing
- All outputs are registered. A byte with `i_RX_DV` high at edge k is acted on at edge k. The resulting state and outputs are visible during cycle k+1.
- A valid `CHK` byte at edge k gives:
  - `o_WR_EN` high during cycles k+1..k+LEN.
  - `o_FRAME_OK` high during cycle k+LEN+1.
  - `o_BUSY` low from cycle k+LEN+1.
- `o_WR_ADDR` and `o_WR_DATA` hold their last values while `o_WR_EN` is low.
- Rejected byte at edge k (bad LEN or bad CHK): `o_FRAME_ERR` high during cycle k+1, and `o_ERR_CNT` updated in the same cycle.
- Timeout: the error fires at the edge where the counter reaches `TIMEOUT_CLKS`, i.e. `TIMEOUT_CLKS` cycles after the last accepted byte.
- If `i_RX_DV` arrives in the same cycle the timeout would fire, the byte takes priority: it is accepted, the counter is cleared, and no error is raised.
- Write strobe rate: at most one write per cycle, with no gaps inside a commit burst.

## Test plan
- Nominal frame `A5 10 02 12 34 34` -> writes (0x10,0x12) then (0x11,0x34) on consecutive cycles, then `o_FRAME_OK` for one cycle; `o_ERR_CNT` stays 0.
- Bad checksum: frame `A5 10 02 12 34 35` -> no `o_WR_EN`, `o_FRAME_ERR` for one cycle, `o_ERR_CNT`=1.
- Address wrap and sync byte inside the payload:
  - `A5 FF 02 A5 02 5A`, where CHK = FF^02^A5^02.
  - Required: writes (0xFF,0xA5) then (0x00,0x02), then `o_FRAME_OK`.
- Length out of range with `MAX_LEN`=8:
  - `A5 00 09` -> error pulse after the `LEN` byte.
  - `A5 00 00` -> error pulse.
  - Required: `o_ERR_CNT`=2 and `o_BUSY` back low.
- Timeout with `TIMEOUT_CLKS` shortened to 100:
  - Send `A5 20` and then nothing -> `o_FRAME_ERR` exactly 100 cycles after the 0x20 DV.
  - A byte arriving on cycle 100 instead -> no error.
- Reset and saturation:
  - Assert `rst_n`=0 during the second write of a 4-byte commit -> no further writes and no `o_FRAME_OK`.
  - Send 300 bad frames -> `o_ERR_CNT` holds at 255.
